// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: instruction-memory req/ack and decode valid/ready handshakes of the fetch stage
interface fetch_sequencer_if #(
    parameter int n = 32
);
    logic         imem_req;
    logic [n-1:0] imem_addr;
    logic         imem_ack;
    logic [n-1:0] imem_rdata;
    logic [n-1:0] instr;
    logic         instr_valid;
    logic         instr_ready;
    modport master (
        output imem_req, imem_addr, instr, instr_valid,
        input  imem_ack, imem_rdata, instr_ready
    );
    modport slave (
        input  imem_req, imem_addr, instr, instr_valid,
        output imem_ack, imem_rdata, instr_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, sequences instruction fetches and applies branch/jump redirects
module fetch_sequencer #(
    parameter int           n        = 32,
    parameter int           i        = 16,
    parameter logic [n-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    fetch_sequencer_if.master   bus,
    input  logic                i_br_taken,
    input  logic [n-1:0]        i_br_pc,
    input  logic [i-1:0]        i_br_imm,
    input  logic                i_jmp,
    input  logic [25:0]         i_jmp_index,
    output logic [n-1:0]        o_pc
);
    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;
    state_t       r_state, w_state_nxt;
    logic [n-1:0] r_pc, r_drop_addr, r_instr;
    logic [n-1:0] w_pc_nxt, w_drop_addr_nxt, w_instr_nxt;
    logic         r_valid, w_valid_nxt;
    logic         w_redir;
    logic [n-1:0] w_br_pc4, w_br_tgt, w_jmp_tgt, w_tgt, w_pc_inc;

    assign w_redir   = i_jmp | i_br_taken;
    assign w_br_pc4  = i_br_pc + n'(4);
    assign w_br_tgt  = w_br_pc4 + {{(n-i-2){i_br_imm[i-1]}}, i_br_imm, 2'b00};
    assign w_jmp_tgt = {w_br_pc4[n-1:28], i_jmp_index, 2'b00};
    assign w_tgt     = i_jmp ? w_jmp_tgt : w_br_tgt;
    assign w_pc_inc  = r_pc + n'(4);

    // DROP keeps presenting the abandoned address so the memory sees a stable request until it acks
    assign bus.imem_req    = (r_state == REQ) || (r_state == DROP);
    assign bus.imem_addr   = (r_state == DROP) ? r_drop_addr : r_pc;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = r_valid;
    assign o_pc            = r_pc;

    // next-state and next-register values; a redirect always wins over the pc+4 step
    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = w_redir ? w_tgt : r_pc;
        w_drop_addr_nxt = r_drop_addr;
        w_instr_nxt     = r_instr;
        w_valid_nxt     = r_valid & ~w_redir;
        case (r_state)
            IDLE: w_state_nxt = REQ;
            REQ: begin
                if (bus.imem_ack && !w_redir) begin
                    w_instr_nxt = bus.imem_rdata;
                    w_valid_nxt = 1'b1;
                    w_pc_nxt    = w_pc_inc;
                    w_state_nxt = HOLD;
                end else if (!bus.imem_ack && w_redir) begin
                    w_drop_addr_nxt = r_pc;
                    w_state_nxt     = DROP;
                end
            end
            HOLD: begin
                if (w_redir || bus.instr_ready) begin
                    w_valid_nxt = 1'b0;
                    w_state_nxt = REQ;
                end
            end
            DROP: w_state_nxt = bus.imem_ack ? REQ : DROP;
            default: w_state_nxt = IDLE;
        endcase
    end

    // state and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pc        <= RESET_PC;
            r_drop_addr <= RESET_PC;
            r_instr     <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_drop_addr <= w_drop_addr_nxt;
            r_instr     <= w_instr_nxt;
            r_valid     <= w_valid_nxt;
        end
    end
endmodule
